// File: rtl/sig_bank_writer.sv
// Drive-side signal bank: NUM_INST*SIGS_PER_INST DW-bit slots presented flat on sig_out (slot = sel*NUM_INST + inst).
// Latency: a single write is visible the cycle after accept; init and broadcast sweeps write one slot per cycle over NSLOT cycles.
// Backpressure: wr_ready is low during reset, while busy (INIT/BCAST), and in a cycle where init_start is raised.
module sig_bank_writer #(
    parameter int NUM_INST      = 3,
    parameter int SIGS_PER_INST = 2,
    parameter int DW            = 32,
    localparam int NSLOT        = NUM_INST * SIGS_PER_INST,
    localparam int IW           = ($clog2(NUM_INST) > 1) ? $clog2(NUM_INST) : 1,
    localparam int SW           = ($clog2(SIGS_PER_INST) > 1) ? $clog2(SIGS_PER_INST) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_start,
    input  logic [31:0]         seed,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [IW-1:0]       wr_inst,
    input  logic [SW-1:0]       wr_sel,
    input  logic                wr_bcast,
    input  logic [DW-1:0]       wr_data,
    output logic [NSLOT*DW-1:0] sig_out,
    output logic                busy,
    output logic                init_done,
    output logic                wr_err
);
    localparam int          KW      = ($clog2(NSLOT) > 1) ? $clog2(NSLOT) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NSLOT - 1);
    localparam logic [IW:0] INST_LIM = (IW + 1)'(NUM_INST);
    localparam logic [SW:0] SEL_LIM  = (SW + 1)'(SIGS_PER_INST);
    localparam logic [31:0] POLY     = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, INIT, BCAST} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] slots [NSLOT];
    logic [31:0]   lfsr;
    logic [DW-1:0] bdata;
    logic [KW-1:0] k;
    logic          wr_acc, in_range, last;
    logic          start_init, start_bcast, single_wr, bad_wr;

    assign wr_ready = rst_n & (state == IDLE) & ~init_start;
    assign busy     = (state != IDLE);
    assign wr_acc   = wr_valid & wr_ready;
    assign in_range = ({1'b0, wr_inst} < INST_LIM) && ({1'b0, wr_sel} < SEL_LIM);

    for (genvar g = 0; g < NSLOT; g++) begin : g_out
        assign sig_out[g*DW +: DW] = slots[g];
    end

    // Next-state and accept decode; init_start in IDLE takes priority over any write.
    always_comb begin
        state_nxt   = state;
        start_init  = 1'b0;
        start_bcast = 1'b0;
        single_wr   = 1'b0;
        bad_wr      = 1'b0;
        last        = (k == LAST_K);
        case (state)
            IDLE: begin
                if (init_start) begin
                    start_init = 1'b1;
                    state_nxt  = INIT;
                end else if (wr_acc && wr_bcast) begin
                    start_bcast = 1'b1;
                    state_nxt   = BCAST;
                end else if (wr_acc) begin
                    single_wr = in_range;
                    bad_wr    = ~in_range;
                end
            end
            INIT, BCAST: begin
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Sweep counter, LFSR, broadcast base value and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= 32'd1;
            bdata     <= '0;
            k         <= '0;
            init_done <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            init_done <= (state == INIT) && last;
            wr_err    <= bad_wr;
            if (start_init) begin
                lfsr <= (seed == 32'd0) ? 32'd1 : seed;
                k    <= '0;
            end else if (start_bcast) begin
                bdata <= wr_data;
                k     <= '0;
            end else if (state != IDLE) begin
                k <= k + 1'b1;
                if (state == INIT) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'd0);
            end
        end
    end

    // Slot bank: sweep writes while busy, indexed single writes while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NSLOT; n++) slots[n] <= '0;
        end else if (state == INIT) begin
            slots[k] <= lfsr[DW-1:0];
        end else if (state == BCAST) begin
            slots[k] <= bdata + DW'(k);
        end else if (single_wr) begin
            for (int s = 0; s < SIGS_PER_INST; s++)
                for (int i = 0; i < NUM_INST; i++)
                    if (wr_sel == SW'(s) && wr_inst == IW'(i))
                        slots[s*NUM_INST + i] <= wr_data;
        end
    end
endmodule
